instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 138 +++++++++++++
 tb/tb_instr_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 16-bit words, decodes them and issues ALU operations
// to the execute stage one at a time, halting on HALT or an illegal opcode.
module instr_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    output logic             o_imem_req,
    output logic [PC_W-1:0]  o_imem_addr,
    input  logic             i_imem_valid,
    input  logic [15:0]      i_imem_data,
    output logic [3:0]       o_rf_rd_add1,
    output logic [3:0]       o_rf_rd_add2,
    output logic [3:0]       o_opcode,
    output logic [3:0]       o_destadd,
    output logic             o_issue,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_error,
    output logic [PC_W-1:0]  o_pc,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_ADD    = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_LSHIFT = 4'b0100;
    localparam logic [3:0] OP_RSHIFT = 4'b1000;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             error_q, error_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        error_d   = error_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (i_start) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                    error_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (i_imem_valid) begin
                    ir_d    = i_imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (ir_q[15:12])
                    OP_ADD, OP_SUB, OP_LSHIFT, OP_RSHIFT: state_d = S_READ;
                    OP_NOP: begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        error_d = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_READ:  state_d = S_ISSUE;
            S_ISSUE: begin
                state_d = S_WAIT;
                pc_d    = pc_q + PC_W'(1);
                if (retired_q != '1) begin
                    retired_d = retired_q + CNT_W'(1);
                end
            end
            S_WAIT:  state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is a function of registered state only, so reset clears them at once.
    always_comb begin
        o_imem_req   = (state_q == S_FETCH);
        o_imem_addr  = pc_q;
        o_pc         = pc_q;
        o_retired    = retired_q;
        o_error      = error_q;
        o_issue      = (state_q == S_ISSUE);
        o_halted     = (state_q == S_HALT);
        o_busy       = (state_q != S_IDLE) && (state_q != S_HALT);
        o_rf_rd_add1 = '0;
        o_rf_rd_add2 = '0;
        o_opcode     = '0;
        o_destadd    = '0;
        if (state_q == S_READ || state_q == S_ISSUE) begin
            o_rf_rd_add1 = ir_q[7:4];
            o_rf_rd_add2 = ir_q[3:0];
        end
        if (state_q == S_ISSUE) begin
            o_opcode  = ir_q[15:12];
            o_destadd = ir_q[11:8];
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a reference interpreter predicts each issue (fields and
// cycle) into a scoreboard that is compared as the sequencer issues.
module tb_instr_sequencer;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic        o_imem_req;
    logic [7:0]  o_imem_addr;
    logic        i_imem_valid;
    logic [15:0] i_imem_data;
    logic [3:0]  o_rf_rd_add1;
    logic [3:0]  o_rf_rd_add2;
    logic [3:0]  o_opcode;
    logic [3:0]  o_destadd;
    logic        o_issue;
    logic        o_busy;
    logic        o_halted;
    logic        o_error;
    logic [7:0]  o_pc;
    logic [15:0] o_retired;

    instr_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_valid (i_imem_valid),
        .i_imem_data  (i_imem_data),
        .o_rf_rd_add1 (o_rf_rd_add1),
        .o_rf_rd_add2 (o_rf_rd_add2),
        .o_opcode     (o_opcode),
        .o_destadd    (o_destadd),
        .o_issue      (o_issue),
        .o_busy       (o_busy),
        .o_halted     (o_halted),
        .o_error      (o_error),
        .o_pc         (o_pc),
        .o_retired    (o_retired)
    );

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  dest;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [7:0]  pc;
        logic [15:0] ret;
        int          cyc;
    } issue_t;

    issue_t      sb[$];
    logic [15:0] mem [256];
    int          mem_delay;
    int          cyc;
    int          base;
    int          n_checks;
    int          n_pass;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    // Instruction memory; outside FETCH it toggles junk onto the bus, which must be ignored.
    initial begin : responder
        int          wcnt;
        logic [7:0]  held;
        wcnt         = 0;
        held         = '0;
        i_imem_valid = 1'b0;
        i_imem_data  = '0;
        forever begin
            @(negedge i_clk);
            if (o_imem_req) begin
                if (wcnt > 0) check("addr_stable", o_imem_addr, held);
                if (wcnt == mem_delay) begin
                    i_imem_valid = 1'b1;
                    i_imem_data  = mem[o_imem_addr];
                    wcnt         = 0;
                end else begin
                    if (wcnt == 0) held = o_imem_addr;
                    i_imem_valid = 1'b0;
                    i_imem_data  = 16'h8FFF;
                    wcnt++;
                end
            end else begin
                wcnt         = 0;
                i_imem_valid = 1'($urandom_range(0, 1));
                i_imem_data  = 16'h8FFF;
            end
        end
    end

    always @(negedge i_clk) begin : monitor
        issue_t e;
        if (o_issue) begin
            if (sb.size() == 0) begin
                check("extra_issue", 1, 0);
            end else begin
                e = sb.pop_front();
                check("iss_op",   o_opcode,     e.op);
                check("iss_dest", o_destadd,    e.dest);
                check("iss_rd1",  o_rf_rd_add1, e.s1);
                check("iss_rd2",  o_rf_rd_add2, e.s2);
                check("iss_pc",   o_pc,         e.pc);
                check("iss_ret",  o_retired,    e.ret);
                check("iss_cyc",  cyc - base,   e.cyc);
            end
        end
        if (o_imem_req) begin
            check("fetch_rd1", o_rf_rd_add1, 0);
            check("fetch_op",  o_opcode,     0);
        end
    end

    // Reference interpreter: FETCH takes d+1 cycles, ALU instr d+5, NOP d+2.
    task automatic predict(input int d, input int max_alu, output int halt_cyc,
                           output logic [7:0] fpc, output logic [15:0] fret, output logic ferr);
        logic [7:0]  pc;
        logic [15:0] ret;
        logic [15:0] w;
        int          t;
        int          nalu;
        issue_t      e;
        pc = '0; ret = '0; t = 0; nalu = 0;
        halt_cyc = -1;
        ferr = 1'b0;
        for (int unsigned step = 0; step < 4000; step++) begin
            w = mem[pc];
            if (w[15:12] == 4'h1 || w[15:12] == 4'h2 || w[15:12] == 4'h4 || w[15:12] == 4'h8) begin
                if (nalu == max_alu) break;
                e.op = w[15:12]; e.dest = w[11:8]; e.s1 = w[7:4]; e.s2 = w[3:0];
                e.pc = pc; e.ret = ret; e.cyc = t + d + 3;
                sb.push_back(e);
                pc = pc + 8'd1;
                if (ret != 16'hFFFF) ret = ret + 16'd1;
                t = t + d + 5;
                nalu++;
            end else if (w[15:12] == 4'h0) begin
                pc = pc + 8'd1;
                t = t + d + 2;
            end else begin
                ferr     = (w[15:12] != 4'hF);
                halt_cyc = t + d + 2;
                break;
            end
        end
        fpc  = pc;
        fret = ret;
    endtask

    task automatic load(input logic [15:0] p [$]);
        for (int unsigned i = 0; i < 256; i++) mem[i] = 16'h7777;
        for (int unsigned i = 0; i < p.size(); i++) mem[i] = p[i];
    endtask

    task automatic start_pulse();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        base = cyc;
        check("start_req",   o_imem_req,  1);
        check("start_addr",  o_imem_addr, 0);
        check("start_err",   o_error,     0);
        check("start_ret",   o_retired,   0);
    endtask

    task automatic run(input string name, input int d, input int glitch);
        int          hc;
        logic [7:0]  fpc;
        logic [15:0] fret;
        logic        ferr;
        bit          done;
        mem_delay = d;
        predict(d, 100000, hc, fpc, fret, ferr);
        start_pulse();
        done = 1'b0;
        for (int i = 1; i < 4000 && !done; i++) begin
            i_start = (i == glitch);
            @(negedge i_clk);
            i_start = 1'b0;
            if (o_halted) done = 1'b1;
        end
        check({name, "_halt_timeout"}, done, 1);
        check({name, "_halt_cyc"},     cyc - base, hc);
        check({name, "_pc"},           o_pc,       fpc);
        check({name, "_retired"},      o_retired,  fret);
        check({name, "_error"},        o_error,    ferr);
        check({name, "_busy"},         o_busy,     0);
        #1;
        check({name, "_sb_empty"},     sb.size(),  0);
        sb.delete();
    endtask

    initial begin : main
        int          hc;
        logic [7:0]  fpc;
        logic [15:0] fret;
        logic        ferr;
        bit          hit;
        logic [15:0] prog [$];
        n_checks  = 0;
        n_pass    = 0;
        base      = 0;
        mem_delay = 0;
        i_reset   = 1'b0;
        i_start   = 1'b0;
        load('{});

        repeat (3) @(negedge i_clk);
        check("rst_req",    o_imem_req, 0);
        check("rst_busy",   o_busy,     0);
        check("rst_halted", o_halted,   0);
        check("rst_issue",  o_issue,    0);
        check("rst_pc",     o_pc,       0);
        check("rst_ret",    o_retired,  0);
        i_reset = 1'b1;
        repeat (4) @(negedge i_clk);
        check("idle_req",   o_imem_req, 0);
        check("idle_busy",  o_busy,     0);

        prog = '{16'h1321, 16'hF000};
        load(prog);
        run("basic", 0, 0);

        prog = '{16'h1321, 16'h0000, 16'h4ABC, 16'h8DEF, 16'hF000};
        load(prog);
        run("slowmem", 3, 6);

        prog = '{16'h0000, 16'h0000, 16'h2456, 16'hF000};
        load(prog);
        run("nops", 0, 0);

        prog = '{16'h3000};
        load(prog);
        run("illegal", 0, 0);
        run("illegal_again", 0, 0);

        // 257 ALU instructions: the 257th must issue from PC 0 after the wrap.
        for (int unsigned i = 0; i < 256; i++) begin
            mem[i] = {4'(1 << (i % 4)), 4'(i), 4'(i >> 4), 4'(i + 3)};
        end
        mem_delay = 0;
        predict(0, 257, hc, fpc, fret, ferr);
        start_pulse();
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge i_clk);
            if (o_issue && o_retired == 16'd256) hit = 1'b1;
        end
        check("wrap_timeout", hit,      1);
        check("wrap_pc",      o_pc,     0);
        check("wrap_err",     o_error,  0);
        #1;
        check("wrap_sb_empty", sb.size(), 0);
        sb.delete();
        i_reset = 1'b0;
        #1;
        check("arst_issue",  o_issue,   0);
        check("arst_op",     o_opcode,  0);
        check("arst_dest",   o_destadd, 0);
        check("arst_busy",   o_busy,    0);
        check("arst_ret",    o_retired, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (4) @(negedge i_clk);
        check("post_rst_req",  o_imem_req, 0);
        check("post_rst_busy", o_busy,     0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
